// File: rtl/ex_mem_req.sv
// EX-stage data request issuer: drives an SRAM-like data port for loads/stores and
// tracks outstanding and dropped responses. Define MEM_REQ_ALE_CHECK_EN to enable misalignment (ale) detection.
module ex_mem_req #(
  parameter int OUTST_MAX = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        ex_ld,
  input  logic        ex_st,
  input  logic [1:0]  ex_size,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_rkd,
  input  logic        ex_cancel,
  input  logic        mem_allow_in,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [3:0]  data_sram_wstrb,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  output logic        ex_ready_go,
  output logic        wait_data_ok,
  output logic        data_ok_fwd,
  output logic        ale,
  output logic [2:0]  outst_cnt,
  output logic [1:0]  dbg_state
);

  // Handshake: data_sram_req stays high with frozen fields until data_sram_addr_ok;
  // the request is accepted in the cycle both are high. The EX inst leaves when
  // ex_ready_go & mem_allow_in. Responses (data_sram_data_ok) return in request order.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_ACC  = 2'd2
  } state_t;

  localparam logic [2:0] MAX_CNT = 3'(OUTST_MAX);

  state_t      r_state;
  state_t      w_next;
  logic        r_pend_drop;
  logic        r_handoff;
  logic [2:0]  r_outst;
  logic [2:0]  r_drop;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [3:0]  r_wstrb;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;

  logic        w_mem_inst;
  logic        w_ale;
  logic        w_accept;
  logic        w_outst_dec;
  logic [2:0]  w_outst_eff;
  logic        w_room;
  logic        w_issue;
  logic        w_drop_inc;
  logic        w_drop_dec;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;

  assign w_mem_inst = ex_valid & (ex_ld | ex_st);

`ifdef MEM_REQ_ALE_CHECK_EN
  assign w_ale = w_mem_inst &
                 (((ex_size == 2'd1) & ex_addr[0]) |
                  ((ex_size == 2'd2) & (ex_addr[1:0] != 2'b00)));
`else
  assign w_ale = 1'b0;
`endif

  always_comb begin
    w_wstrb = 4'b0000;
    w_wdata = ex_rkd;
    case (ex_size)
      2'd0: begin
        w_wdata = {4{ex_rkd[7:0]}};
        if (ex_st) w_wstrb = 4'b0001 << ex_addr[1:0];
      end
      2'd1: begin
        w_wdata = {2{ex_rkd[15:0]}};
        if (ex_st) w_wstrb = ex_addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        if (ex_st) w_wstrb = 4'b1111;
      end
    endcase
  end

  assign w_accept    = (r_state == S_REQ) & data_sram_addr_ok;
  // A response in this cycle frees a slot, so a full window can refill without a bubble.
  assign w_outst_dec = data_sram_data_ok & (r_outst != 3'd0);
  assign w_outst_eff = r_outst - {2'b00, w_outst_dec};
  assign w_room      = w_outst_eff < MAX_CNT;
  assign w_issue     = (r_state == S_IDLE) & w_mem_inst & ~ex_cancel & ~w_ale &
                       w_room & ~r_handoff;
  assign w_drop_inc  = (w_accept & (r_pend_drop | ex_cancel)) |
                       ((r_state == S_ACC) & ex_cancel);
  assign w_drop_dec  = data_sram_data_ok & (r_drop != 3'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_issue) w_next = S_REQ;
      S_REQ: begin
        if (data_sram_addr_ok) begin
          if (r_pend_drop | ex_cancel | mem_allow_in) w_next = S_IDLE;
          else                                        w_next = S_ACC;
        end
      end
      S_ACC: if (mem_allow_in | ex_cancel) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    data_sram_req = (r_state == S_REQ);
    ex_ready_go   = 1'b0;
    if (~w_mem_inst | w_ale | ex_cancel) begin
      ex_ready_go = 1'b1;
    end else begin
      case (r_state)
        S_REQ:   ex_ready_go = data_sram_addr_ok & ~r_pend_drop;
        S_ACC:   ex_ready_go = 1'b1;
        default: ex_ready_go = 1'b0;
      endcase
    end
    wait_data_ok = w_mem_inst & ~ex_cancel &
                   ((w_accept & ~r_pend_drop) | (r_state == S_ACC));
  end

  // A cancel while waiting for addr_ok cannot withdraw the request; remember to drop its response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pend_drop <= 1'b0;
      r_handoff   <= 1'b0;
    end else begin
      if (w_accept)                          r_pend_drop <= 1'b0;
      else if ((r_state == S_REQ) & ex_cancel) r_pend_drop <= 1'b1;
      r_handoff <= (r_state == S_ACC) & (w_next == S_IDLE) & ~ex_cancel;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outst <= 3'd0;
      r_drop  <= 3'd0;
    end else begin
      r_outst <= r_outst + {2'b00, w_accept} - {2'b00, w_outst_dec};
      r_drop  <= r_drop + {2'b00, w_drop_inc} - {2'b00, w_drop_dec};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr    <= 1'b0;
      r_size  <= 2'd0;
      r_wstrb <= 4'b0000;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
    end else if (w_issue) begin
      r_wr    <= ex_st;
      r_size  <= ex_size;
      r_wstrb <= w_wstrb;
      r_addr  <= ex_addr;
      r_wdata <= w_wdata;
    end
  end

  assign data_sram_wr    = r_wr;
  assign data_sram_size  = r_size;
  assign data_sram_wstrb = r_wstrb;
  assign data_sram_addr  = r_addr;
  assign data_sram_wdata = r_wdata;
  // Responses with nothing outstanding (e.g. stragglers from before a reset) are ignored.
  assign data_ok_fwd     = data_sram_data_ok & (r_drop == 3'd0) & (r_outst != 3'd0);
  assign ale             = w_ale;
  assign outst_cnt       = r_outst;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_ex_mem_req.sv
// Self-checking bench for ex_mem_req: scoreboard of expected request fields plus
// directed checks of handshake, counters, cancel/drop and reset behaviour.
module tb_ex_mem_req;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid, ex_ld, ex_st, ex_cancel, mem_allow_in;
  logic [1:0]  ex_size;
  logic [31:0] ex_addr, ex_rkd;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic        ex_ready_go, wait_data_ok, data_ok_fwd, ale;
  logic [2:0]  outst_cnt;
  logic [1:0]  dbg_state;

  int          n_total = 0;
  int          n_bad   = 0;
  logic [70:0] exp_q[$];
  logic [70:0] last_req;
  logic [70:0] popped;

  always #5 clk = ~clk;

  ex_mem_req #(.OUTST_MAX(2)) dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ld(ex_ld), .ex_st(ex_st), .ex_size(ex_size),
    .ex_addr(ex_addr), .ex_rkd(ex_rkd), .ex_cancel(ex_cancel),
    .mem_allow_in(mem_allow_in),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .ex_ready_go(ex_ready_go), .wait_data_ok(wait_data_ok),
    .data_ok_fwd(data_ok_fwd), .ale(ale), .outst_cnt(outst_cnt),
    .dbg_state(dbg_state)
  );

  task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] exp_wstrb(input logic st, input logic [1:0] size,
                                           input logic [31:0] addr);
    if (!st) return 4'b0000;
    case (size)
      2'd0:    return 4'b0001 << addr[1:0];
      2'd1:    return addr[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] size, input logic [31:0] rkd);
    case (size)
      2'd0:    return {4{rkd[7:0]}};
      2'd1:    return {2{rkd[15:0]}};
      default: return rkd;
    endcase
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inst(input logic st, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] rkd);
    ex_valid = 1'b1;
    ex_ld    = ~st;
    ex_st    = st;
    ex_size  = size;
    ex_addr  = addr;
    ex_rkd   = rkd;
  endtask

  task automatic push_exp(input logic st, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] rkd);
    exp_q.push_back({st, size, exp_wstrb(st, size, addr), addr, exp_wdata(size, rkd)});
  endtask

  task automatic clear_inst();
    ex_valid = 1'b0;
    ex_ld    = 1'b0;
    ex_st    = 1'b0;
  endtask

  // Full access: issue, hold `delay` cycles without addr_ok, then accept with mem_allow_in=1.
  task automatic do_access(input logic st, input logic [1:0] size, input logic [31:0] addr,
                           input logic [31:0] rkd, input int delay);
    set_inst(st, size, addr, rkd);
    mem_allow_in = 1'b1;
    push_exp(st, size, addr, rkd);
    #1;
    check_eq("issue_rdy", 72'(ex_ready_go), 72'(1'b0));
    check_eq("issue_req", 72'(data_sram_req), 72'(1'b0));
    cyc();
    for (int i = 0; i < delay; i++) begin
      check_eq("wait_req", 72'(data_sram_req), 72'(1'b1));
      check_eq("wait_rdy", 72'(ex_ready_go), 72'(1'b0));
      cyc();
    end
    data_sram_addr_ok = 1'b1;
    #1;
    check_eq("acc_rdy", 72'(ex_ready_go), 72'(1'b1));
    check_eq("acc_wdok", 72'(wait_data_ok), 72'(1'b1));
    last_req = {data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata};
    cyc();
    data_sram_addr_ok = 1'b0;
    clear_inst();
  endtask

  task automatic give_data_ok(input logic exp_fwd);
    data_sram_data_ok = 1'b1;
    #1;
    check_eq("fwd", 72'(data_ok_fwd), 72'(exp_fwd));
    cyc();
    data_sram_data_ok = 1'b0;
  endtask

  // Request monitor: every req cycle must show the fields of the oldest expected request.
  always @(negedge clk) begin
    if (!reset && data_sram_req) begin
      if (exp_q.size() == 0) begin
        check_eq("unexp_req", 72'(data_sram_req), 72'(1'b0));
      end else begin
        check_eq("req_fields",
                 72'({data_sram_wr, data_sram_size, data_sram_wstrb, data_sram_addr, data_sram_wdata}),
                 72'(exp_q[0]));
        if (data_sram_addr_ok) popped = exp_q.pop_front();
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear_inst();
    ex_size = 2'd0; ex_addr = 32'd0; ex_rkd = 32'd0; ex_cancel = 1'b0;
    mem_allow_in = 1'b1; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req", 72'(data_sram_req), 72'(1'b0));
    check_eq("rst_wr", 72'(data_sram_wr), 72'(1'b0));
    check_eq("rst_size", 72'(data_sram_size), 72'(2'd0));
    check_eq("rst_wstrb", 72'(data_sram_wstrb), 72'(4'd0));
    check_eq("rst_addr", 72'(data_sram_addr), 72'(32'd0));
    check_eq("rst_wdata", 72'(data_sram_wdata), 72'(32'd0));
    check_eq("rst_outst", 72'(outst_cnt), 72'(3'd0));
    check_eq("rst_state", 72'(dbg_state), 72'(2'd0));
    reset = 1'b0;
    cyc();

    // Store word, immediate addr_ok
    do_access(1'b1, 2'd2, 32'h1000, 32'h11223344, 0);
    check_eq("sw_wstrb", 72'(last_req[67:64]), 72'(4'b1111));
    check_eq("sw_wdata", 72'(last_req[31:0]), 72'(32'h11223344));
    check_eq("sw_outst", 72'(outst_cnt), 72'(3'd1));
    check_eq("sw_req_low", 72'(data_sram_req), 72'(1'b0));
    give_data_ok(1'b1);
    check_eq("sw_outst0", 72'(outst_cnt), 72'(3'd0));

    // Store byte at offset 3
    do_access(1'b1, 2'd0, 32'h1003, 32'h000000AB, 0);
    check_eq("sb_wstrb", 72'(last_req[67:64]), 72'(4'b1000));
    check_eq("sb_wdata", 72'(last_req[31:0]), 72'(32'hABABABAB));
    check_eq("sb_size", 72'(last_req[69:68]), 72'(2'd0));
    give_data_ok(1'b1);

    // Load with addr_ok delayed 3 cycles
    do_access(1'b0, 2'd2, 32'h2000, 32'h0, 3);
    check_eq("lw_wstrb", 72'(last_req[67:64]), 72'(4'b0000));
    give_data_ok(1'b1);

    // Store half, upper half-word
    do_access(1'b1, 2'd1, 32'h2002, 32'hBEEF1234, 1);
    check_eq("sh_wstrb", 72'(last_req[67:64]), 72'(4'b1100));
    check_eq("sh_wdata", 72'(last_req[31:0]), 72'(32'h12341234));
    give_data_ok(1'b1);

    // Cancel while waiting for addr_ok: request stays up, response dropped
    set_inst(1'b0, 2'd2, 32'h3000, 32'h0);
    push_exp(1'b0, 2'd2, 32'h3000, 32'h0);
    cyc();
    ex_cancel = 1'b1;
    #1;
    check_eq("cx_req", 72'(data_sram_req), 72'(1'b1));
    check_eq("cx_rdy", 72'(ex_ready_go), 72'(1'b1));
    check_eq("cx_wdok", 72'(wait_data_ok), 72'(1'b0));
    cyc();
    ex_cancel = 1'b0;
    clear_inst();
    #1;
    check_eq("cx_hold", 72'(data_sram_req), 72'(1'b1));
    cyc();
    data_sram_addr_ok = 1'b1;
    #1;
    check_eq("cx_acc_wdok", 72'(wait_data_ok), 72'(1'b0));
    cyc();
    data_sram_addr_ok = 1'b0;
    #1;
    check_eq("cx_idle", 72'(data_sram_req), 72'(1'b0));
    check_eq("cx_outst", 72'(outst_cnt), 72'(3'd1));
    give_data_ok(1'b0);
    check_eq("cx_outst0", 72'(outst_cnt), 72'(3'd0));
    do_access(1'b0, 2'd2, 32'h3004, 32'h0, 0);
    give_data_ok(1'b1);

    // Accept while MEM is busy: ACC state, then hand-off
    set_inst(1'b0, 2'd2, 32'h4000, 32'h0);
    push_exp(1'b0, 2'd2, 32'h4000, 32'h0);
    cyc();
    data_sram_addr_ok = 1'b1;
    mem_allow_in = 1'b0;
    #1;
    check_eq("acc_in_rdy", 72'(ex_ready_go), 72'(1'b1));
    cyc();
    data_sram_addr_ok = 1'b0;
    #1;
    check_eq("acc_state", 72'(dbg_state), 72'(2'd2));
    check_eq("acc_req", 72'(data_sram_req), 72'(1'b0));
    check_eq("acc_rdy2", 72'(ex_ready_go), 72'(1'b1));
    check_eq("acc_wdok2", 72'(wait_data_ok), 72'(1'b1));
    mem_allow_in = 1'b1;
    cyc();
    clear_inst();
    check_eq("acc_idle", 72'(dbg_state), 72'(2'd0));
    give_data_ok(1'b1);

    // Cancel in ACC: response dropped
    set_inst(1'b0, 2'd2, 32'h4004, 32'h0);
    push_exp(1'b0, 2'd2, 32'h4004, 32'h0);
    cyc();
    data_sram_addr_ok = 1'b1;
    mem_allow_in = 1'b0;
    cyc();
    data_sram_addr_ok = 1'b0;
    ex_cancel = 1'b1;
    #1;
    check_eq("accx_rdy", 72'(ex_ready_go), 72'(1'b1));
    check_eq("accx_wdok", 72'(wait_data_ok), 72'(1'b0));
    cyc();
    ex_cancel = 1'b0;
    clear_inst();
    mem_allow_in = 1'b1;
    check_eq("accx_idle", 72'(dbg_state), 72'(2'd0));
    give_data_ok(1'b0);
    check_eq("accx_outst0", 72'(outst_cnt), 72'(3'd0));

    // Outstanding limit: third load held until a response frees a slot
    do_access(1'b0, 2'd2, 32'h5000, 32'h0, 0);
    do_access(1'b0, 2'd2, 32'h5004, 32'h0, 0);
    check_eq("full_outst", 72'(outst_cnt), 72'(3'd2));
    set_inst(1'b0, 2'd2, 32'h5008, 32'h0);
    push_exp(1'b0, 2'd2, 32'h5008, 32'h0);
    #1;
    check_eq("full_rdy", 72'(ex_ready_go), 72'(1'b0));
    cyc();
    check_eq("full_hold", 72'(data_sram_req), 72'(1'b0));
    check_eq("full_rdy2", 72'(ex_ready_go), 72'(1'b0));
    data_sram_data_ok = 1'b1;
    #1;
    check_eq("full_fwd", 72'(data_ok_fwd), 72'(1'b1));
    cyc();
    data_sram_data_ok = 1'b0;
    #1;
    check_eq("full_issue", 72'(data_sram_req), 72'(1'b1));
    check_eq("full_outst1", 72'(outst_cnt), 72'(3'd1));
    data_sram_addr_ok = 1'b1;
    #1;
    check_eq("full_acc_rdy", 72'(ex_ready_go), 72'(1'b1));
    cyc();
    data_sram_addr_ok = 1'b0;
    clear_inst();
    check_eq("full_outst2", 72'(outst_cnt), 72'(3'd2));
    give_data_ok(1'b1);
    give_data_ok(1'b1);
    check_eq("full_outst0", 72'(outst_cnt), 72'(3'd0));

    // Misaligned word load
    set_inst(1'b0, 2'd2, 32'h1002, 32'h0);
    #1;
`ifdef MEM_REQ_ALE_CHECK_EN
    check_eq("ale_flag", 72'(ale), 72'(1'b1));
    check_eq("ale_rdy", 72'(ex_ready_go), 72'(1'b1));
    cyc();
    check_eq("ale_noreq", 72'(data_sram_req), 72'(1'b0));
    cyc();
    check_eq("ale_noreq2", 72'(data_sram_req), 72'(1'b0));
    clear_inst();
`else
    check_eq("ale_off", 72'(ale), 72'(1'b0));
    clear_inst();
    cyc();
    do_access(1'b0, 2'd2, 32'h1002, 32'h0, 0);
    check_eq("ale_off_addr", 72'(last_req[63:32]), 72'(32'h1002));
    give_data_ok(1'b1);
`endif

    // Asynchronous reset mid-operation
    do_access(1'b0, 2'd2, 32'h6000, 32'h0, 0);
    set_inst(1'b0, 2'd2, 32'h6004, 32'h0);
    push_exp(1'b0, 2'd2, 32'h6004, 32'h0);
    cyc();
    #2;
    reset = 1'b1;
    #1;
    check_eq("arst_req", 72'(data_sram_req), 72'(1'b0));
    check_eq("arst_outst", 72'(outst_cnt), 72'(3'd0));
    check_eq("arst_state", 72'(dbg_state), 72'(2'd0));
    check_eq("arst_addr", 72'(data_sram_addr), 72'(32'd0));
    exp_q.delete();
    clear_inst();
    cyc();
    reset = 1'b0;
    cyc();
    data_sram_data_ok = 1'b1;
    #1;
    check_eq("arst_stray_fwd", 72'(data_ok_fwd), 72'(1'b0));
    cyc();
    data_sram_data_ok = 1'b0;
    check_eq("arst_stray_outst", 72'(outst_cnt), 72'(3'd0));
    do_access(1'b1, 2'd0, 32'h7001, 32'h0000005A, 2);
    check_eq("post_rst_wstrb", 72'(last_req[67:64]), 72'(4'b0010));
    give_data_ok(1'b1);

    check_eq("q_empty", 72'(exp_q.size()), 72'(0));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ex_mem_req.md
EX_MEM_REQ -- requirements
Module: ex_mem_req

Interface
REQ-001 Parameter SHALL be: OUTST_MAX, 2, maximum data requests accepted (addr_ok) but not yet answered (data_ok); legal range 1..7.
REQ-002 Port clk  in  1  sole clock; all state updates on posedge.
REQ-003 Port reset  in  1  asynchronous, active-high reset.
REQ-004 Ports from EX: ex_valid in 1 valid inst; ex_ld in 1 load; ex_st in 1 store; ex_size in 2 (0 byte, 1 half, 2 word); ex_addr in 32 effective address; ex_rkd in 32 store data; ex_cancel in 1 flush from exception/ertn.
REQ-005 Port mem_allow_in  in  1  downstream MEM stage can accept.
REQ-006 SRAM-like ports: data_sram_req out 1; data_sram_wr out 1; data_sram_size out 2; data_sram_wstrb out 4; data_sram_addr out 32; data_sram_wdata out 32; data_sram_addr_ok in 1; data_sram_data_ok in 1.
REQ-007 Ports to pipeline: ex_ready_go out 1; wait_data_ok out 1, travels with inst to MEM; data_ok_fwd out 1, data_ok with dropped responses removed; ale out 1, misaligned-address flag; outst_cnt out 3.

Function
REQ-008 FSM SHALL have states IDLE, REQ (req high, awaiting addr_ok), ACC (addr accepted, awaiting mem_allow_in).
REQ-009 IDLE->REQ when ex_valid & (ex_ld|ex_st) & ~ex_cancel & ~ale & outst_cnt<OUTST_MAX & ~(state==IDLE after an ACC hand-off of the same inst); request fields latched at this edge, req high the following cycle (1-cycle latency).
REQ-010 data_sram_req SHALL equal (state==REQ); addr, size, wr, wstrb, wdata SHALL stay stable while req high.
REQ-011 REQ->IDLE on addr_ok & mem_allow_in; REQ->ACC on addr_ok & ~mem_allow_in; ACC->IDLE on mem_allow_in.
REQ-012 ex_ready_go SHALL be 1 for non-memory inst, for ale inst, when ex_cancel, in REQ on addr_ok cycle, and in ACC; 0 otherwise.
REQ-013 wait_data_ok SHALL be 1 when the inst leaving EX had its request accepted and was not cancelled.
REQ-014 wstrb: byte = 4'b0001<<addr[1:0]; half = addr[1]?4'b1100:4'b0011; word = 4'b1111; loads 4'b0000.
REQ-015 wdata: byte = rkd[7:0] replicated x4; half = rkd[15:0] replicated x2; word = rkd.
REQ-016 data_sram_addr SHALL be ex_addr unmodified; data_sram_size = ex_size.
REQ-017 outst_cnt: +1 on req&addr_ok without data_ok, -1 on data_ok without req&addr_ok, unchanged when both or neither.
REQ-018 Request SHALL NOT be withdrawn once req high; ex_cancel in REQ sets a pending-drop flag, FSM stays REQ until addr_ok, then IDLE.
REQ-019 drop_cnt (3 bits) SHALL increment when a cancelled request gets addr_ok, and when ex_cancel arrives in ACC; each data_ok while drop_cnt>0 decrements it and is suppressed from data_ok_fwd.
REQ-020 data_ok_fwd SHALL equal data_sram_data_ok & (drop_cnt==0).
REQ-021 New request SHALL be blocked while outst_cnt==OUTST_MAX; ex_ready_go stays 0 meanwhile.

Reset
REQ-022 Reset SHALL asynchronously force state=IDLE, outst_cnt=0, drop_cnt=0, pending-drop=0, data_sram_req=0, wr=0, wstrb=0, addr=0, wdata=0, size=0.
REQ-023 Reset mid-operation SHALL abandon all outstanding transactions; no data_ok_fwd until a new request is accepted.

Configuration
REQ-024 Macro MEM_REQ_ALE_CHECK_EN: defined -> ale=1 for half with addr[0]=1 or word with addr[1:0]!=0, no request issued, ex_ready_go=1 same cycle.
REQ-025 Undefined -> ale tied 0, all addresses issued unmodified.

Verification
REQ-026 Store word addr 0x1000 rkd 0x11223344, addr_ok 1st req cycle, mem_allow_in=1 -> one req cycle, wstrb 1111, wdata 0x11223344, outst_cnt 1.
REQ-027 Store byte addr 0x1003 rkd 0xAB -> wstrb 1000, wdata 0xABABABAB, size 0.
REQ-028 Load, addr_ok delayed 3 cycles -> req held high with stable fields 3 cycles, ex_ready_go 0 until addr_ok cycle.
REQ-029 ex_cancel in REQ, addr_ok 2 cycles later, then data_ok -> drop_cnt 1->0, data_ok_fwd stays 0, wait_data_ok 0.
REQ-030 OUTST_MAX=2, two accepted loads, no data_ok -> third held, req low; one data_ok -> third issued next cycle.
REQ-031 With MEM_REQ_ALE_CHECK_EN, ld.w addr 0x1002 -> ale=1, req never asserted, ex_ready_go=1.
